ooo_decode_execute_stage_buf: RTL
=================================

Name: ooo_decode_execute_stage_buf

Overview:
- Pipeline buffer between the OoO decode stage and the execute stage.
- Holds decoded packets in a 2-entry FIFO with a valid/ready handshake.
- Issues the head packet to execute only when its target scalar functional unit (SFU) is not stalled. Absorbs decode/execute rate mismatch without a combinational ready path back to decode.
- Handles pipeline flush and halt-instruction drain.

Parameters:
- PKT_W, 256, width of the flattened decoded packet (pc, pc4, instr, immediate, port_a/b, control structs); opaque to this block.
- DEPTH, 2, entry count; legal values 2 or 4 (power of two).
- SFU_W, 2, width of the SFU type code (0 arith, 1 mult, 2 div, 3 loadstore).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- dec_valid  in  1  decode offers a packet
- dec_ready  out  1  buffer accepts; registered, equals "not full"
- dec_pkt  in  PKT_W  decoded packet payload
- dec_sfu_type  in  SFU_W  target functional unit of the packet
- dec_halt  in  1  packet is a halt instruction
- stall_arith, stall_multiply, stall_divide, stall_loadstore  in  1 each  per-SFU busy
- flush  in  1  squash all buffered packets (branch mispredict / exception)
- ex_valid  out  1  head packet issued this cycle
- ex_pkt  out  PKT_W  head payload
- ex_sfu_type  out  SFU_W  head SFU type
- ex_halt  out  1  head is a halt
- halted  out  1  halt packet has issued; set until flush
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, RST=1): pointers 0, count 0, halted 0, dec_ready 0 while RST held, 1 on the first cycle after release. ex_valid 0. ex_pkt, ex_sfu_type, ex_halt are 0 (FIFO storage is cleared).
- Accept: push when dec_valid & dec_ready at a rising CLK. The write pointer increments modulo DEPTH (wrap-around).
- Issue: ex_valid = (count != 0) & !stall_sel & !halted & !flush. stall_sel is the stall input selected by the head's sfu_type.
  - ex_valid is combinational from registered state plus the stall/flush inputs.
  - Pop at the same edge when ex_valid=1; execute never back-pressures after ex_valid.
  - Outputs present the head entry whenever count != 0, and zero when count = 0.
- Latency: an empty buffer with an unstalled FU presents an accepted packet on ex_valid in the next cycle (1-cycle latency). There is no bypass.
- Simultaneous push and pop: count unchanged. Allowed while full only if dec_ready was 1 the previous cycle; dec_ready is registered, so no push occurs while full.
- dec_ready(next) = (count_next < DEPTH) & !halted_next & !halt_pending. halt_pending means a halt packet is already in the buffer; once one is accepted, no further packets are accepted.
- Halt: when the head issues with ex_halt=1, halted sets next cycle. ex_valid is then held 0 and dec_ready 0 until flush.
- Flush: synchronous and highest priority. Next state: count 0, pointers 0, halted 0, halt_pending 0.
  - Any push in the same cycle is dropped.
  - ex_valid is forced 0 in the flush cycle.
  - dec_ready is 1 in the cycle after.
- In-order only: a stalled head blocks younger packets even if their FU is free.
- Reset mid-operation: all state cleared immediately; no partial packet is ever emitted.

Optional Feature:
- Macro DE_STAGE_PERF_CNT_EN.
- Defined: adds four 32-bit saturating counters plus output ports stall_cnt_arith, stall_cnt_mult, stall_cnt_div, stall_cnt_ls.
  - A counter increments each cycle where count != 0 and the head's SFU is stalled (and no flush).
  - Counters saturate at 0xFFFF_FFFF, clear on RST only, and are unaffected by flush.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, push pkt A (sfu=0), no stalls -> dec_ready=1 cycle after reset; A on ex_valid next cycle with ex_pkt=A, count returns 0.
- Push A(sfu=1), B(sfu=0) back-to-back with stall_multiply=1 for 3 cycles -> count=2, dec_ready=0; ex_valid=0 for 3 cycles; A issues, then B next cycle (in order).
- Fill to DEPTH=2 and keep dec_valid=1 with continuous pops -> steady 1 packet/cycle after fill. Pointer wrap verified over 10 packets with payload = sequence index 0..9 arriving in order.
- Push halt packet H then C -> C not accepted (dec_ready=0 after H accepted). H issues with ex_halt=1, halted=1 next cycle, ex_valid stays 0. Flush -> halted=0, dec_ready=1.
- count=2 plus dec_valid with flush asserted same cycle -> next cycle count=0, no ex_valid in flush cycle, pushed packet discarded.
- With DE_STAGE_PERF_CNT_EN: head sfu=2 with stall_divide=1 for 5 cycles -> stall_cnt_div=5, other counters 0. Flush does not clear stall_cnt_div.

Source files
------------

// File: rtl/ooo_decode_execute_stage_buf.sv
// ooo_decode_execute_stage_buf: in-order FIFO between OoO decode and execute with per-SFU stall issue, flush and halt drain
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   dec_valid/dec_ready      decode handshake; dec_ready is registered ("not full, no halt seen")
//   dec_pkt/dec_sfu_type     decoded payload and its target functional unit
//   dec_halt                 payload is a halt instruction
//   stall_*                  per-SFU busy (arith, multiply, divide, loadstore)
//   flush                    squash everything buffered
//   ex_valid/ex_pkt/...      head packet issued to execute (zero when empty)
//   halted                   a halt has issued; cleared by flush
//   count                    occupancy
// Optional: DE_STAGE_PERF_CNT_EN adds saturating per-SFU stall counters stall_cnt_*.
module ooo_decode_execute_stage_buf #(
    parameter int PKT_W = 256,
    parameter int DEPTH = 2,
    parameter int SFU_W = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [PKT_W-1:0]           dec_pkt,
    input  logic [SFU_W-1:0]           dec_sfu_type,
    input  logic                       dec_halt,
    input  logic                       stall_arith,
    input  logic                       stall_multiply,
    input  logic                       stall_divide,
    input  logic                       stall_loadstore,
    input  logic                       flush,
    output logic                       ex_valid,
    output logic [PKT_W-1:0]           ex_pkt,
    output logic [SFU_W-1:0]           ex_sfu_type,
    output logic                       ex_halt,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     count
`ifdef DE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt_arith,
    output logic [31:0]                stall_cnt_mult,
    output logic [31:0]                stall_cnt_div,
    output logic [31:0]                stall_cnt_ls
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PKT_W-1:0] mem_pkt [DEPTH];
    logic [SFU_W-1:0] mem_sfu [DEPTH];
    logic [DEPTH-1:0] mem_halt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             halt_pending, has_head, stall_sel, push;
    logic             halted_next, halt_pending_next;
    logic [CW-1:0]    count_next;

    assign has_head    = count != '0;
    assign ex_pkt      = has_head ? mem_pkt[rd_ptr] : '0;
    assign ex_sfu_type = has_head ? mem_sfu[rd_ptr] : '0;
    assign ex_halt     = has_head & mem_halt[rd_ptr];
    assign stall_sel   = (ex_sfu_type == SFU_W'(0)) ? stall_arith :
                         (ex_sfu_type == SFU_W'(1)) ? stall_multiply :
                         (ex_sfu_type == SFU_W'(2)) ? stall_divide : stall_loadstore;
    assign ex_valid    = has_head & !stall_sel & !halted & !flush;
    // flush drops a same-cycle push
    assign push        = dec_valid & dec_ready & !flush;
    assign count_next  = flush ? '0 : count + CW'(push) - CW'(ex_valid);
    assign halted_next = !flush & (halted | (ex_valid & ex_halt));
    // once a halt is buffered, decode is closed until flush
    assign halt_pending_next = !flush & (halt_pending | (push & dec_halt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            halted       <= 1'b0;
            halt_pending <= 1'b0;
            dec_ready    <= 1'b0;
            mem_halt     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_pkt[k] <= '0;
                mem_sfu[k] <= '0;
            end
        end else begin
            count        <= count_next;
            halted       <= halted_next;
            halt_pending <= halt_pending_next;
            dec_ready    <= (count_next < FULL) & !halted_next & !halt_pending_next;
            wr_ptr       <= flush ? '0 : wr_ptr + AW'(push);
            rd_ptr       <= flush ? '0 : rd_ptr + AW'(ex_valid);
            if (push) begin
                mem_pkt[wr_ptr]  <= dec_pkt;
                mem_sfu[wr_ptr]  <= dec_sfu_type;
                mem_halt[wr_ptr] <= dec_halt;
            end
        end
    end

`ifdef DE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt [4];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 4; k++) stall_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (has_head & stall_sel & !flush & (ex_sfu_type == SFU_W'(k)) & ~&stall_cnt[k])
                    stall_cnt[k] <= stall_cnt[k] + 32'd1;
        end
    end

    assign stall_cnt_arith = stall_cnt[0];
    assign stall_cnt_mult  = stall_cnt[1];
    assign stall_cnt_div   = stall_cnt[2];
    assign stall_cnt_ls    = stall_cnt[3];
`endif
endmodule
